// File: rtl/de0_input_conditioner.sv
// Push-button conditioner: synchronise, debounce, edge pulses, reset stretch.
// Optional long-press detector enabled by defining DE0_INPUT_LONGPRESS_EN.
//
// Ports:
//   clk_clk       in   clock, all state on rising edge
//   reset_reset_n in   async active-low reset
//   raw_in        in   [NUM_CH] raw buttons (ACTIVE_LOW=1: 0 = pressed)
//   sw_rst_n      in   raw reset switch, 0 requests system reset
//   level_out     out  [NUM_CH] debounced level, 1 = pressed
//   rise_pulse    out  [NUM_CH] one cycle on press
//   fall_pulse    out  [NUM_CH] one cycle on release
//   sys_reset_n   out  stretched, registered active-low reset
//   long_pulse    out  [NUM_CH] one cycle on long press
module de0_input_conditioner #(
   parameter int NUM_CH          = 3,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [NUM_CH-1:0] raw_in,
   input  logic              sw_rst_n,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              sys_reset_n,
   output logic [NUM_CH-1:0] long_pulse
);

   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam logic [NUM_CH-1:0] REL = {NUM_CH{ACTIVE_LOW}};

   typedef enum logic {
      HOLD = 1'b0,
      RUN  = 1'b1
   } rst_state_e;

   logic [NUM_CH-1:0]            raw_s1_q, raw_s2_q;
   logic                         sw_s1_q, sw_s2_q;
   logic [NUM_CH-1:0]            pressed;
   logic [NUM_CH-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic [NUM_CH-1:0]            level_q, level_d;
   logic [NUM_CH-1:0]            rise_q, fall_q;
   rst_state_e                   state_q, state_d;
   logic [HW-1:0]                hold_q, hold_d;

   // Synchronisers idle at the released level so reset looks like no press.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         raw_s1_q <= REL;
         raw_s2_q <= REL;
         sw_s1_q  <= 1'b1;
         sw_s2_q  <= 1'b1;
      end else begin
         raw_s1_q <= raw_in;
         raw_s2_q <= raw_s1_q;
         sw_s1_q  <= sw_rst_n;
         sw_s2_q  <= sw_s1_q;
      end
   end

   assign pressed = ACTIVE_LOW ? ~raw_s2_q : raw_s2_q;

   // Any sample matching the accepted level wipes the count.
   always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pressed[i] == level_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d[i]  = ~level_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         db_cnt_q <= '0;
         level_q  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         rise_q   <= level_d & ~level_q;
         fall_q   <= ~level_d & level_q;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         HOLD: begin
            if (!sw_s2_q) begin
               hold_d = '0;
            end else if (hold_q == HW'(RST_HOLD_CYCLES - 1)) begin
               state_d = RUN;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         RUN: begin
            if (!sw_s2_q) begin
               state_d = HOLD;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = HOLD;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= HOLD;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // RUN encodes as 1, so this is the state flop itself.
   assign sys_reset_n = (state_q == RUN);
   assign level_out   = level_q;
   assign rise_pulse  = rise_q & {NUM_CH{sys_reset_n}};
   assign fall_pulse  = fall_q & {NUM_CH{sys_reset_n}};

`ifdef DE0_INPUT_LONGPRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);

   logic [NUM_CH-1:0][LW-1:0] lp_cnt_q, lp_cnt_d;
   logic [NUM_CH-1:0]         long_q, long_d;

   // Count parks at LONG_CYCLES so a held button fires only once.
   always_comb begin
      lp_cnt_d = lp_cnt_q;
      long_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!level_q[i]) begin
            lp_cnt_d[i] = '0;
         end else if (lp_cnt_q[i] != LW'(LONG_CYCLES)) begin
            lp_cnt_d[i] = lp_cnt_q[i] + LW'(1);
         end
         long_d[i] = level_q[i] &&
                     (lp_cnt_q[i] == LW'(LONG_CYCLES - 1));
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         lp_cnt_q <= '0;
         long_q   <= '0;
      end else begin
         lp_cnt_q <= lp_cnt_d;
         long_q   <= long_d;
      end
   end

   assign long_pulse = long_q & {NUM_CH{sys_reset_n}};
`else
   assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_de0_input_conditioner.sv
// Scoreboard bench for de0_input_conditioner (small parameters).
// Expected output slices are queued per cycle as stimulus is driven.
module tb_de0_input_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] raw;
   logic       sw;
   logic [2:0] level_out, rise_pulse, fall_pulse, long_pulse;
   logic       sys_reset_n;
   logic [12:0] obs;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          cyc;
      string       tag;
      logic [12:0] m;
      logic [12:0] v;
   } exp_t;

   exp_t sb[$];

`ifdef DE0_INPUT_LONGPRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   de0_input_conditioner #(
      .NUM_CH(3),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(16),
      .ACTIVE_LOW(1'b1),
      .RST_HOLD_CYCLES(3),
      .LONG_CYCLES(8)
   ) dut (
      .clk_clk(clk),
      .reset_reset_n(rst_n),
      .raw_in(raw),
      .sw_rst_n(sw),
      .level_out(level_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .sys_reset_n(sys_reset_n),
      .long_pulse(long_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign obs = {long_pulse, fall_pulse, rise_pulse, level_out, sys_reset_n};

   function automatic logic [12:0] bt(input int pos);
      logic [12:0] one;
      one = 13'd1;
      return one << pos;
   endfunction

   function automatic logic [12:0] LV(input int i); return bt(1 + i); endfunction
   function automatic logic [12:0] RS(input int i); return bt(4 + i); endfunction
   function automatic logic [12:0] FL(input int i); return bt(7 + i); endfunction
   function automatic logic [12:0] LG(input int i); return bt(10 + i); endfunction

   localparam logic [12:0] SRN    = 13'h0001;
   localparam logic [12:0] LV_ALL = 13'h000E;
   localparam logic [12:0] RS_ALL = 13'h0070;
   localparam logic [12:0] FL_ALL = 13'h0380;
   localparam logic [12:0] LG_ALL = 13'h1C00;

   task automatic chk(input string tag, input logic [12:0] got,
                      input logic [12:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, want);
      end
   endtask

   task automatic sb_push(input int c, input string tag,
                          input logic [12:0] m, input logic [12:0] v);
      exp_t e;
      e.cyc = c;
      e.tag = tag;
      e.m   = m;
      e.v   = v & m;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            chk(sb[i].tag, obs & sb[i].m, sb[i].v);
            sb.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, queue %0d", sb.size());
      $fatal(1);
   end

   initial begin
      int k, j, f, r, m0;
      logic [12:0] lg_exp;
      lg_exp = LP_EN ? LG(0) : 13'h0;

      rst_n = 1'b1;
      raw   = 3'b111;
      sw    = 1'b1;
      #3 rst_n = 1'b0;
      #1 chk("rst_init", obs, 13'h0);

      // release: hold counter needs 3 cycles before RUN
      tick(2);
      rst_n = 1'b1;
      k = cyc;
      sb_push(k + 2, "boot_hold", 13'h1FFF, 13'h0);
      sb_push(k + 3, "boot_run", SRN, SRN);
      tick(6);

      // clean press / release on ch0
      k = cyc;
      raw[0] = 1'b0;
      sb_push(k + 5, "p0_pre", LV(0) | RS(0) | FL(0), 13'h0);
      sb_push(k + 6, "p0_rise", LV(0) | RS(0) | FL(0), LV(0) | RS(0));
      sb_push(k + 7, "p0_post", LV(0) | RS(0) | FL(0), LV(0));
      tick(10);
      j = cyc;
      raw[0] = 1'b1;
      sb_push(j + 5, "r0_pre", LV(0) | FL(0), LV(0));
      sb_push(j + 6, "r0_fall", LV(0) | RS(0) | FL(0), FL(0));
      sb_push(j + 7, "r0_post", LV(0) | FL(0), 13'h0);
      tick(9);

      // bounce on ch1: low 3, high 1, then low steady
      k = cyc;
      f = k + 4;
      for (int c = k + 1; c <= f + 5; c++)
         sb_push(c, "bnc_hold", LV(1) | RS(1), 13'h0);
      sb_push(f + 6, "bnc_rise", LV(1) | RS(1), LV(1) | RS(1));
      sb_push(f + 7, "bnc_post", LV(1) | RS(1), LV(1));
      raw[1] = 1'b0;
      tick(3);
      raw[1] = 1'b1;
      tick(1);
      raw[1] = 1'b0;
      tick(9);
      j = cyc;
      raw[1] = 1'b1;
      sb_push(j + 6, "bnc_fall", LV(1) | FL(1), FL(1));
      tick(9);

      // all channels together
      k = cyc;
      raw = 3'b000;
      sb_push(k + 5, "all_pre", LV_ALL | RS_ALL, 13'h0);
      sb_push(k + 6, "all_rise", LV_ALL | RS_ALL, LV_ALL | RS_ALL);
      sb_push(k + 7, "all_post", LV_ALL | RS_ALL, LV_ALL);
      tick(8);
      j = cyc;
      raw = 3'b111;
      sb_push(j + 6, "all_fall", LV_ALL | RS_ALL | FL_ALL, FL_ALL);
      sb_push(j + 7, "all_fpost", LV_ALL | FL_ALL, 13'h0);
      tick(9);

      // reset sequencer, ch2 press completes during HOLD
      j = cyc;
      k = j + 1;
      raw[2] = 1'b0;
      sb_push(k + 2, "seq_run", SRN, SRN);
      sb_push(k + 3, "seq_hold", SRN, 13'h0);
      sb_push(k + 4, "seq_lvl0", LV(2) | RS(2), 13'h0);
      sb_push(k + 5, "seq_hold2", SRN, 13'h0);
      sb_push(k + 5, "seq_quiet", LV(2) | RS(2), LV(2));
      sb_push(k + 6, "seq_back", SRN, SRN);
      sb_push(k + 6, "seq_nopls", LV(2) | RS(2), LV(2));
      tick(1);
      sw = 1'b0;
      tick(1);
      sw = 1'b1;
      tick(8);
      j = cyc;
      raw[2] = 1'b1;
      sb_push(j + 6, "seq_fall", LV(2) | FL(2), FL(2));
      tick(9);

      // long press on ch0: level at +6, long pulse 8 later
      k = cyc;
      raw[0] = 1'b0;
      sb_push(k + 6, "lp_lvl", LV(0) | RS(0), LV(0) | RS(0));
      sb_push(k + 13, "lp_pre", LG(0), 13'h0);
      sb_push(k + 14, "lp_fire", LG(0), lg_exp);
      sb_push(k + 15, "lp_post", LG(0), 13'h0);
      sb_push(k + 19, "lp_sat", LG(0), 13'h0);
      tick(20);
      raw[0] = 1'b1;
      tick(9);

      // reset mid-debounce: ch0 held, ch1 count at 3
      raw[0] = 1'b0;
      tick(8);
      k = cyc;
      raw[1] = 1'b0;
      sb_push(k + 5, "mid_pre", LV(0) | LV(1) | SRN, LV(0) | SRN);
      tick(5);
      rst_n = 1'b0;
      #1 chk("rst_mid", obs, 13'h0);
      raw = 3'b111;
      tick(2);
      rst_n = 1'b1;
      r = cyc;
      for (int c = r + 1; c <= r + 8; c++)
         sb_push(c, "mid_quiet", LV_ALL | RS_ALL | FL_ALL | LG_ALL, 13'h0);
      sb_push(r + 2, "mid_hold", SRN, 13'h0);
      sb_push(r + 3, "mid_run", SRN, SRN);
      tick(10);
      m0 = cyc;
      raw[1] = 1'b0;
      sb_push(m0 + 5, "mid_fresh0", LV(1) | RS(1), 13'h0);
      sb_push(m0 + 6, "mid_fresh1", LV(1) | RS(1), LV(1) | RS(1));
      tick(8);
      raw = 3'b111;
      tick(10);

      chk("sb_drain", 13'(sb.size()), 13'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
